vector_issue: RTL and testbench
===============================

VECTOR_ISSUE -- requirements
Module: vector_issue

Interface
REQ-001 Parameters SHALL be: N=32 (lane width); Q=16 (fraction bits, pass-through only); WIDTH_VECTOR=24 (lanes); WIDTH_OPCODE=4; REGS=8 (vector registers); RA=3 (register address width); TIMEOUT=255 (max execute wait cycles).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rstn  in  1  asynchronous, active-low reset.
REQ-004 instr_valid  in  1  instruction offered.
REQ-005 instr_ready  out  1  instruction accepted when high with instr_valid.
REQ-006 instr_opcode  in  WIDTH_OPCODE  operation code.
REQ-007 instr_rd / instr_ra / instr_rb  in  RA each  destination / source A / source B register.
REQ-008 instr_imm  in  WIDTH_VECTOR  signed immediate.
REQ-009 instr_mask  in  WIDTH_VECTOR  per-lane enable.
REQ-010 enable_alu  out  WIDTH_VECTOR  lane enables to execute stage.
REQ-011 opcode  out  WIDTH_OPCODE  operation to execute stage.
REQ-012 dataA / dataB  out  WIDTH_VECTOR*N  signed lane operands, lane i at bits [i*N +: N].
REQ-013 data_imm  out  WIDTH_VECTOR  signed immediate to execute stage.
REQ-014 ex_valid / ex_zero  in  1 each  execute-stage result valid / all-enabled-lanes-zero.
REQ-015 ex_data  in  WIDTH_VECTOR*N  execute-stage result.
REQ-016 host_we  in  1;  host_waddr  in  RA;  host_wdata  in  WIDTH_VECTOR*N  register preload.
REQ-017 host_raddr  in  RA;  host_rdata  out  WIDTH_VECTOR*N  combinational register readback.
REQ-018 zero_flag  out  1  zero result of last completed instruction.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 timeout_err  out  1  sticky execute-timeout flag.

Function
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT, WB.
REQ-022 In IDLE, instr_ready SHALL be 1; on instr_valid the block SHALL latch opcode, rd, imm, mask and registers ra/rb contents, then go to ISSUE (opcode 4'b0000 = NOP: latch nothing, remain IDLE).
REQ-023 In ISSUE, enable_alu SHALL equal latched mask, dataA/dataB/opcode/data_imm SHALL carry latched values; next state WAIT.
REQ-024 enable_alu, opcode, dataA, dataB, data_imm SHALL remain stable through ISSUE and WAIT; in IDLE and WB enable_alu SHALL be 0, other outputs hold last values.
REQ-025 In WAIT, ex_valid=1 SHALL move to WB in the next cycle, capturing ex_data and ex_zero; ex_valid in ISSUE SHALL be ignored.
REQ-026 A 9-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle; reaching TIMEOUT without ex_valid SHALL set timeout_err, skip writeback, return to IDLE.
REQ-027 In WB, for each lane i with mask[i]=1, register rd lane i SHALL be written with captured ex_data lane i; lanes with mask[i]=0 SHALL keep old value; zero_flag SHALL take captured ex_zero; next state IDLE.
REQ-028 Minimum latency accept-to-register-update SHALL be 4 cycles (IDLE accept, ISSUE, WAIT with ex_valid, WB); instr_ready SHALL be 0 outside IDLE.
REQ-029 host_we SHALL write all lanes of host_waddr only in IDLE and only when instr_valid=0; in any other case the host write SHALL be dropped.
REQ-030 An operand read of a register written by WB in the previous instruction SHALL return the updated value (register write completes before the next IDLE accept).
REQ-031 rd equal to ra or rb SHALL be legal; operands SHALL be the pre-instruction values.
REQ-032 mask all-zero SHALL still traverse ISSUE/WAIT; no lanes written, zero_flag updated.

Reset
REQ-033 rstn low SHALL asynchronously force IDLE, instr_ready=1, busy=0, enable_alu=0, opcode=0, dataA=dataB=0, data_imm=0, zero_flag=0, timeout_err=0, counter=0, all registers=0.
REQ-034 Reset during ISSUE/WAIT/WB SHALL abort the instruction with no register write.
REQ-035 timeout_err SHALL clear only on reset.

Verification
REQ-036 Host write r1=lanes 5, r2=lanes 3; instr ra=1 rb=2 rd=3 mask=all ones; ex_valid after 2 WAIT cycles with ex_data lanes 8 -> r3 all lanes 8, busy high 5 cycles.
REQ-037 mask=24'h00000F, r3 preloaded lanes 7, ex_data lanes 1 -> r3 lanes 0-3 = 1, lanes 4-23 = 7.
REQ-038 ex_valid never asserted -> return to IDLE after 255 WAIT cycles, timeout_err=1, rd unchanged, next instruction accepted.
REQ-039 host_we during WAIT -> register unchanged; host_we in IDLE with instr_valid=1 -> write dropped, instruction accepted.
REQ-040 ex_zero=1 in WB -> zero_flag=1; rstn pulsed mid-WAIT -> all outputs at REQ-033 values, no write.
REQ-041 Back-to-back instructions with rd of first = ra of second -> second operand equals first result.

Source files
------------

// File: rtl/vector_issue_if.sv
// Instruction and execute-stage channels of the vector issue stage.
// master = instruction source / execute stage, slave = vector_issue.
interface vector_issue_if #(
    parameter int N            = 32,
    parameter int WIDTH_VECTOR = 24,
    parameter int WIDTH_OPCODE = 4,
    parameter int RA           = 3
);
    logic                        instr_valid;
    logic                        instr_ready;
    logic [WIDTH_OPCODE-1:0]     instr_opcode;
    logic [RA-1:0]               instr_rd;
    logic [RA-1:0]               instr_ra;
    logic [RA-1:0]               instr_rb;
    logic [WIDTH_VECTOR-1:0]     instr_imm;
    logic [WIDTH_VECTOR-1:0]     instr_mask;

    logic [WIDTH_VECTOR-1:0]     enable_alu;
    logic [WIDTH_OPCODE-1:0]     opcode;
    logic [WIDTH_VECTOR*N-1:0]   dataA;
    logic [WIDTH_VECTOR*N-1:0]   dataB;
    logic [WIDTH_VECTOR-1:0]     data_imm;

    logic                        ex_valid;
    logic                        ex_zero;
    logic [WIDTH_VECTOR*N-1:0]   ex_data;

    modport master (
        output instr_valid, instr_opcode, instr_rd, instr_ra, instr_rb,
               instr_imm, instr_mask,
        input  instr_ready,
        input  enable_alu, opcode, dataA, dataB, data_imm,
        output ex_valid, ex_zero, ex_data
    );

    modport slave (
        input  instr_valid, instr_opcode, instr_rd, instr_ra, instr_rb,
               instr_imm, instr_mask,
        output instr_ready,
        output enable_alu, opcode, dataA, dataB, data_imm,
        input  ex_valid, ex_zero, ex_data
    );
endinterface

// File: rtl/vector_issue.sv
// Vector issue stage: latches an instruction and its register operands, hands them
// to the execute stage, waits for the result and writes it back lane-masked.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for an instruction; host preload allowed
// S_ISSUE | operands presented to execute stage, ex_valid ignored
// S_WAIT  | waiting for ex_valid, bounded by TIMEOUT cycles
// S_WB    | lane-masked write of captured result, zero_flag update
module vector_issue #(
    parameter int N            = 32,
    parameter int Q            = 16,
    parameter int WIDTH_VECTOR = 24,
    parameter int WIDTH_OPCODE = 4,
    parameter int REGS         = 8,
    parameter int RA           = 3,
    parameter int TIMEOUT      = 255
) (
    input  logic                        clk,
    input  logic                        rstn,
    vector_issue_if.slave               bus,
    input  logic                        host_we,
    input  logic [RA-1:0]               host_waddr,
    input  logic [WIDTH_VECTOR*N-1:0]   host_wdata,
    input  logic [RA-1:0]               host_raddr,
    output logic [WIDTH_VECTOR*N-1:0]   host_rdata,
    output logic                        zero_flag,
    output logic                        busy,
    output logic                        timeout_err
);
    localparam int LW = WIDTH_VECTOR * N;

    // Fraction bits only travel with the data; they must still fit in a lane.
    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("vector_issue: Q must lie in [0, N)");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

    state_t                    state;
    logic [8:0]                wait_cnt;
    logic                      ready_q;
    logic [WIDTH_VECTOR-1:0]   enable_q;
    logic [WIDTH_OPCODE-1:0]   opcode_q;
    logic [LW-1:0]             data_a_q;
    logic [LW-1:0]             data_b_q;
    logic [WIDTH_VECTOR-1:0]   imm_q;
    logic [RA-1:0]             rd_q;
    logic [WIDTH_VECTOR-1:0]   mask_q;
    logic [LW-1:0]             result_q;
    logic                      ex_zero_q;
    logic [LW-1:0]             regs [REGS];

    assign bus.instr_ready = ready_q;
    assign bus.enable_alu  = enable_q;
    assign bus.opcode      = opcode_q;
    assign bus.dataA       = data_a_q;
    assign bus.dataB       = data_b_q;
    assign bus.data_imm    = imm_q;
    assign host_rdata      = regs[host_raddr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            ready_q     <= 1'b1;
            busy        <= 1'b0;
            enable_q    <= '0;
            opcode_q    <= '0;
            data_a_q    <= '0;
            data_b_q    <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            mask_q      <= '0;
            result_q    <= '0;
            ex_zero_q   <= 1'b0;
            zero_flag   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Opcode zero is a NOP: accepted but nothing latched.
                    if (bus.instr_valid && bus.instr_opcode != '0) begin
                        state    <= S_ISSUE;
                        ready_q  <= 1'b0;
                        busy     <= 1'b1;
                        enable_q <= bus.instr_mask;
                        opcode_q <= bus.instr_opcode;
                        data_a_q <= regs[bus.instr_ra];
                        data_b_q <= regs[bus.instr_rb];
                        imm_q    <= bus.instr_imm;
                        rd_q     <= bus.instr_rd;
                        mask_q   <= bus.instr_mask;
                    end
                end
                S_ISSUE: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 9'd1;
                    if (bus.ex_valid) begin
                        state     <= S_WB;
                        enable_q  <= '0;
                        result_q  <= bus.ex_data;
                        ex_zero_q <= bus.ex_zero;
                    end else if (wait_cnt == 9'(TIMEOUT - 1)) begin
                        state       <= S_IDLE;
                        enable_q    <= '0;
                        ready_q     <= 1'b1;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                S_WB: begin
                    state     <= S_IDLE;
                    ready_q   <= 1'b1;
                    busy      <= 1'b0;
                    zero_flag <= ex_zero_q;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Host preload only lands when no instruction can be accepted in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < REGS; r++) regs[r] <= '0;
        end else if (state == S_WB) begin
            for (int i = 0; i < WIDTH_VECTOR; i++) begin
                if (mask_q[i]) regs[rd_q][i*N +: N] <= result_q[i*N +: N];
            end
        end else if (state == S_IDLE && host_we && !bus.instr_valid) begin
            regs[host_waddr] <= host_wdata;
        end
    end
endmodule

// File: tb/tb_vector_issue.sv
// Directed bench for vector_issue: transaction-level model of the register file and
// issue outputs, checked every cycle, plus literal pins on the model and DUT.
module tb_vector_issue;
    localparam int N  = 32;
    localparam int WV = 24;
    localparam int LW = N * WV;

    logic            clk;
    logic            rstn;
    logic            host_we;
    logic [2:0]      host_waddr;
    logic [LW-1:0]   host_wdata;
    logic [2:0]      host_raddr;
    logic [LW-1:0]   host_rdata;
    logic            zero_flag;
    logic            busy;
    logic            timeout_err;

    vector_issue_if #(.N(N), .WIDTH_VECTOR(WV), .WIDTH_OPCODE(4), .RA(3)) bus ();

    vector_issue #(
        .N(N), .Q(16), .WIDTH_VECTOR(WV), .WIDTH_OPCODE(4),
        .REGS(8), .RA(3), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
        .host_raddr(host_raddr), .host_rdata(host_rdata),
        .zero_flag(zero_flag), .busy(busy), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int busy_cnt = 0;

    // Model: register file per lane, plus what the issue outputs must show.
    logic [N-1:0]    mreg [8][WV];
    logic            exp_busy;
    logic [WV-1:0]   exp_en;
    logic [3:0]      exp_op;
    logic [LW-1:0]   exp_a;
    logic [LW-1:0]   exp_b;
    logic [WV-1:0]   exp_imm;
    logic            exp_zf;
    logic            exp_terr;

    function automatic logic [LW-1:0] pack(input int r);
        logic [LW-1:0] v;
        for (int i = 0; i < WV; i++) v[i*N +: N] = mreg[r][i];
        return v;
    endfunction

    function automatic logic [LW-1:0] lanes(input logic [N-1:0] x);
        logic [LW-1:0] v;
        for (int i = 0; i < WV; i++) v[i*N +: N] = x;
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < WV; i++) mreg[r][i] = '0;
        exp_busy = 1'b0; exp_en = '0; exp_op = '0; exp_a = '0; exp_b = '0;
        exp_imm = '0; exp_zf = 1'b0; exp_terr = 1'b0;
    endtask

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Per-cycle compare, sampled on the falling edge; walks host_raddr over all registers.
    initial begin : compare
        int ridx = 0;
        forever begin
            @(negedge clk);
            chk("instr_ready", LW'(bus.instr_ready), LW'(!exp_busy));
            chk("busy", LW'(busy), LW'(exp_busy));
            chk("enable_alu", LW'(bus.enable_alu), LW'(exp_en));
            chk("opcode", LW'(bus.opcode), LW'(exp_op));
            chk("dataA", bus.dataA, exp_a);
            chk("dataB", bus.dataB, exp_b);
            chk("data_imm", LW'(bus.data_imm), LW'(exp_imm));
            chk("zero_flag", LW'(zero_flag), LW'(exp_zf));
            chk("timeout_err", LW'(timeout_err), LW'(exp_terr));
            if (busy) busy_cnt++;
            host_raddr = 3'(ridx);
            #1;
            chk("host_rdata", host_rdata, pack(ridx));
            ridx = (ridx + 1) % 8;
        end
    end

    task automatic host_write(input int a, input logic [LW-1:0] d);
        host_we = 1'b1; host_waddr = 3'(a); host_wdata = d;
        @(posedge clk); #1;
        host_we = 1'b0;
        for (int i = 0; i < WV; i++) mreg[a][i] = d[i*N +: N];
    endtask

    task automatic nop_instr();
        bus.instr_valid = 1'b1; bus.instr_opcode = 4'h0;
        bus.instr_rd = 3'd1; bus.instr_ra = 3'd2; bus.instr_rb = 3'd3;
        bus.instr_imm = 24'hABCDEF; bus.instr_mask = 24'hFFFFFF;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
    endtask

    // nwait: WAIT cycles before ex_valid, <0 = never. poke: 1 host write with accept,
    // 2 host write in first WAIT cycle. abort_at>0: reset pulse after that many WAIT cycles.
    task automatic run_instr(input logic [3:0] op, input int rd, input int ra, input int rb,
                             input logic [WV-1:0] imm, input logic [WV-1:0] mask,
                             input int nwait, input logic [LW-1:0] res, input logic zero,
                             input int poke, input int abort_at);
        busy_cnt = 0;
        bus.instr_valid = 1'b1; bus.instr_opcode = op;
        bus.instr_rd = 3'(rd); bus.instr_ra = 3'(ra); bus.instr_rb = 3'(rb);
        bus.instr_imm = imm; bus.instr_mask = mask;
        if (poke == 1) begin
            host_we = 1'b1; host_waddr = 3'd5; host_wdata = lanes(32'hDEAD0001);
        end
        @(posedge clk); #1;
        bus.instr_valid = 1'b0; host_we = 1'b0;
        exp_busy = 1'b1; exp_en = mask; exp_op = op;
        exp_a = pack(ra); exp_b = pack(rb); exp_imm = imm;
        // Result offered during ISSUE must be ignored.
        bus.ex_valid = 1'b1; bus.ex_data = ~res; bus.ex_zero = ~zero;
        @(posedge clk); #1;
        bus.ex_valid = 1'b0; bus.ex_data = '0; bus.ex_zero = 1'b0;
        if (poke == 2) begin
            host_we = 1'b1; host_waddr = 3'd5; host_wdata = lanes(32'hDEAD0002);
        end
        if (abort_at > 0) begin
            repeat (abort_at) begin
                @(posedge clk); #1;
                host_we = 1'b0;
            end
            rstn = 1'b0;
            model_reset();
            @(posedge clk); #1;
            rstn = 1'b1;
            return;
        end
        if (nwait < 0) begin
            repeat (255) begin
                @(posedge clk); #1;
                host_we = 1'b0;
            end
            exp_busy = 1'b0; exp_en = '0; exp_terr = 1'b1;
            return;
        end
        repeat (nwait) begin
            @(posedge clk); #1;
            host_we = 1'b0;
        end
        bus.ex_valid = 1'b1; bus.ex_data = res; bus.ex_zero = zero;
        @(posedge clk); #1;
        host_we = 1'b0;
        bus.ex_valid = 1'b0; bus.ex_data = '0; bus.ex_zero = 1'b0;
        exp_en = '0;
        @(posedge clk); #1;
        for (int i = 0; i < WV; i++) if (mask[i]) mreg[rd][i] = res[i*N +: N];
        exp_zf = zero; exp_busy = 1'b0;
    endtask

    initial begin : driver
        logic [LW-1:0] pat;
        for (int i = 0; i < WV; i++) pat[i*N +: N] = 32'(100 + i);
        rstn = 1'b0; host_we = 1'b0; host_waddr = '0; host_wdata = '0;
        bus.instr_valid = 1'b0; bus.instr_opcode = '0; bus.instr_rd = '0;
        bus.instr_ra = '0; bus.instr_rb = '0; bus.instr_imm = '0; bus.instr_mask = '0;
        bus.ex_valid = 1'b0; bus.ex_zero = 1'b0; bus.ex_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        chk("reset_ready", LW'(bus.instr_ready), LW'(1'b1));
        chk("reset_busy", LW'(busy), LW'(1'b0));

        host_write(1, lanes(32'd5));
        host_write(2, lanes(32'd3));
        run_instr(4'h1, 3, 1, 2, 24'h000123, 24'hFFFFFF, 2, lanes(32'd8), 1'b0, 0, 0);
        chk("basic_r3", pack(3), {24{32'd8}});
        chk("basic_busy_cycles", LW'(busy_cnt), LW'(5));

        host_write(3, lanes(32'd7));
        run_instr(4'h2, 3, 1, 2, 24'hFFFFF0, 24'h00000F, 0, lanes(32'd1), 1'b0, 0, 0);
        chk("mask_r3", pack(3), {{20{32'd7}}, {4{32'd1}}});
        chk("min_busy_cycles", LW'(busy_cnt), LW'(3));

        nop_instr();
        run_instr(4'h3, 2, 2, 1, 24'h800000, 24'hFFFFFF, 1, lanes(32'd11), 1'b0, 0, 0);
        chk("rd_eq_ra_r2", pack(2), {24{32'd11}});

        run_instr(4'h4, 4, 1, 2, 24'h000001, 24'hFFFFFF, 0, pat, 1'b0, 0, 0);
        run_instr(4'h5, 0, 4, 3, 24'h000002, 24'h000000, 0, lanes(32'd0), 1'b1, 0, 0);
        chk("fwd_dataA", bus.dataA, pat);
        chk("zero_flag_set", LW'(zero_flag), LW'(1'b1));
        chk("empty_mask_r0", pack(0), '0);

        run_instr(4'h6, 5, 1, 1, 24'h000003, 24'h000000, 2, lanes(32'd9), 1'b0, 2, 0);
        run_instr(4'h7, 0, 1, 1, 24'h000004, 24'h000000, 0, lanes(32'd9), 1'b0, 1, 0);
        chk("host_drop_r5", pack(5), '0);

        host_write(6, lanes(32'd6));
        run_instr(4'h8, 6, 1, 2, 24'h000005, 24'hFFFFFF, -1, lanes(32'd0), 1'b0, 0, 0);
        chk("timeout_err", LW'(timeout_err), LW'(1'b1));
        chk("timeout_busy_cycles", LW'(busy_cnt), LW'(256));
        chk("timeout_r6", pack(6), {24{32'd6}});
        run_instr(4'h9, 6, 6, 1, 24'h000006, 24'hFFFFFF, 0, lanes(32'd2), 1'b0, 0, 0);
        chk("after_timeout_r6", pack(6), {24{32'd2}});
        chk("timeout_sticky", LW'(timeout_err), LW'(1'b1));

        run_instr(4'hA, 7, 1, 2, 24'h000007, 24'hFFFFFF, 0, lanes(32'd4), 1'b0, 0, 3);
        chk("abort_timeout_err", LW'(timeout_err), LW'(1'b0));
        chk("abort_r1", pack(1), '0);
        host_write(1, lanes(32'd21));
        run_instr(4'hB, 7, 1, 1, 24'h000008, 24'h0000FF, 0, lanes(32'd13), 1'b0, 0, 0);
        chk("post_reset_r7", pack(7), {{16{32'd0}}, {8{32'd13}}});

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
